// File: rtl/rob_if.sv
// Reorder buffer bus: rename-stage dispatch, CDB completion, branch rollback,
// and the retire / free-list return path. Master = rename/FL side, slave = ROB.
interface rob_if #(
  parameter int NUM_ROB  = 8,
  parameter int NUM_PR   = 64,
  parameter int NUM_FL   = 32,
  parameter int NUM_ARCH = 32
);
  localparam int RW = $clog2(NUM_ROB);
  localparam int PW = $clog2(NUM_PR);
  localparam int FW = $clog2(NUM_FL);
  localparam int AW = $clog2(NUM_ARCH);

  logic          dispatch_en;
  logic [AW-1:0] dispatch_dest;
  logic [PW-1:0] dispatch_T;
  logic [PW-1:0] dispatch_T_old;
  logic [FW-1:0] dispatch_FL_idx;
  logic          complete_en;
  logic [RW-1:0] complete_rob_idx;
  logic          rollback_en;
  logic [RW-1:0] rollback_rob_idx;

  logic          rob_valid;
  logic [RW-1:0] rob_idx;
  logic          retire_en;
  logic [AW-1:0] retire_dest;
  logic [PW-1:0] retire_T;
  logic [PW-1:0] T_old_idx;
  logic [FW-1:0] FL_rollback_idx;

  modport master (
    output dispatch_en, dispatch_dest, dispatch_T, dispatch_T_old, dispatch_FL_idx,
           complete_en, complete_rob_idx, rollback_en, rollback_rob_idx,
    input  rob_valid, rob_idx, retire_en, retire_dest, retire_T, T_old_idx,
           FL_rollback_idx
  );

  modport slave (
    input  dispatch_en, dispatch_dest, dispatch_T, dispatch_T_old, dispatch_FL_idx,
           complete_en, complete_rob_idx, rollback_en, rollback_rob_idx,
    output rob_valid, rob_idx, retire_en, retire_dest, retire_T, T_old_idx,
           FL_rollback_idx
  );
endinterface

// File: rtl/rob.sv
// Reorder buffer for the rename pipeline. Circular buffer with head (oldest),
// tail (next free slot) and an occupancy count that can reach NUM_ROB.
// Retire and rollback outputs are combinational from registered state.
// Optional macro ROB_DEBUG_EN adds rob_head/rob_tail/rob_count observation ports.
module rob #(
  parameter int NUM_ROB  = 8,
  parameter int NUM_PR   = 64,
  parameter int NUM_FL   = 32,
  parameter int NUM_ARCH = 32
) (
  input  logic clock,
  input  logic reset,
  rob_if.slave bus
`ifdef ROB_DEBUG_EN
  ,
  output logic [$clog2(NUM_ROB)-1:0] rob_head,
  output logic [$clog2(NUM_ROB)-1:0] rob_tail,
  output logic [$clog2(NUM_ROB):0]   rob_count
`endif
);
  localparam int RW = $clog2(NUM_ROB);
  localparam int PW = $clog2(NUM_PR);
  localparam int FW = $clog2(NUM_FL);
  localparam int AW = $clog2(NUM_ARCH);
  localparam logic [RW:0] FULL = (RW+1)'(NUM_ROB);

  logic [RW-1:0]      head_q, head_d;
  logic [RW-1:0]      tail_q, tail_d;
  logic [RW:0]        count_q, count_d;
  logic [NUM_ROB-1:0] valid_q, valid_d;
  logic [NUM_ROB-1:0] complete_q, complete_d;
  logic [AW-1:0]      dest_q  [NUM_ROB];
  logic [PW-1:0]      t_q     [NUM_ROB];
  logic [PW-1:0]      t_old_q [NUM_ROB];
  logic [FW-1:0]      fl_q    [NUM_ROB];

  logic               rob_free;
  logic               do_disp;
  logic               do_ret;
  logic               rb_ok;
  logic [RW-1:0]      rb_nxt;
  logic [RW-1:0]      rb_off;
  logic               rb_younger;
  logic [NUM_ROB-1:0] squash;

  // Control decode: dispatch/retire qualification and rollback squash mask.
  // An entry is younger than the branch when its distance from head exceeds
  // the branch's distance from head; this handles wrap without extra state.
  always_comb begin
    rob_free   = (count_q != FULL);
    do_disp    = bus.dispatch_en && rob_free && !bus.rollback_en;
    do_ret     = valid_q[head_q] && complete_q[head_q] && !bus.rollback_en;
    rb_ok      = bus.rollback_en && valid_q[bus.rollback_rob_idx];
    rb_nxt     = bus.rollback_rob_idx + RW'(1);
    rb_off     = bus.rollback_rob_idx - head_q;
    // With a full ROB, rb_nxt can wrap onto head (older), so exclude tail slot.
    rb_younger = (rb_nxt != tail_q) && valid_q[rb_nxt];
    squash     = '0;
    for (int i = 0; i < NUM_ROB; i++) begin
      squash[i] = rb_ok && valid_q[i] && ((RW'(i) - head_q) > rb_off);
    end
  end

  // Next-state for pointers, occupancy and per-entry status bits.
  always_comb begin
    valid_d    = valid_q;
    complete_d = complete_q;
    if (bus.complete_en && valid_q[bus.complete_rob_idx] && !squash[bus.complete_rob_idx]) begin
      complete_d[bus.complete_rob_idx] = 1'b1;
    end
    if (do_ret) begin
      valid_d[head_q]    = 1'b0;
      complete_d[head_q] = 1'b0;
    end
    if (do_disp) begin
      valid_d[tail_q]    = 1'b1;
      complete_d[tail_q] = 1'b0;
    end
    for (int i = 0; i < NUM_ROB; i++) begin
      if (squash[i]) begin
        valid_d[i]    = 1'b0;
        complete_d[i] = 1'b0;
      end
    end
    head_d = head_q + RW'(do_ret);
    if (rb_ok) begin
      tail_d  = rb_nxt;
      count_d = {1'b0, rb_off} + (RW+1)'(1);
    end else begin
      tail_d  = tail_q + RW'(do_disp);
      count_d = count_q + (RW+1)'(do_disp) - (RW+1)'(do_ret);
    end
  end

  // State registers and entry payload written at the tail on dispatch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      complete_q <= '0;
      for (int i = 0; i < NUM_ROB; i++) begin
        dest_q[i]  <= '0;
        t_q[i]     <= '0;
        t_old_q[i] <= '0;
        fl_q[i]    <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      complete_q <= complete_d;
      if (do_disp) begin
        dest_q[tail_q]  <= bus.dispatch_dest;
        t_q[tail_q]     <= bus.dispatch_T;
        t_old_q[tail_q] <= bus.dispatch_T_old;
        fl_q[tail_q]    <= bus.dispatch_FL_idx;
      end
    end
  end

  assign bus.rob_valid       = rob_free;
  assign bus.rob_idx         = tail_q;
  assign bus.retire_en       = do_ret;
  assign bus.retire_dest     = do_ret ? dest_q[head_q]  : '0;
  assign bus.retire_T        = do_ret ? t_q[head_q]     : '0;
  assign bus.T_old_idx       = do_ret ? t_old_q[head_q] : '0;
  // Nothing younger allocated means the FL head is still the live one.
  assign bus.FL_rollback_idx = !rb_ok     ? '0 :
                               rb_younger ? fl_q[rb_nxt] : bus.dispatch_FL_idx;

`ifdef ROB_DEBUG_EN
  assign rob_head  = head_q;
  assign rob_tail  = tail_q;
  assign rob_count = count_q;
`endif
endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: stimulus pushes expected retirements into a queue,
// an independent monitor pops and compares whenever retire_en is seen.
module tb_rob;
  localparam int NUM_ROB = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  rob_if #(.NUM_ROB(NUM_ROB), .NUM_PR(64), .NUM_FL(32), .NUM_ARCH(32)) bus ();

`ifdef ROB_DEBUG_EN
  logic [2:0] dbg_head, dbg_tail;
  logic [3:0] dbg_count;
  rob #(.NUM_ROB(NUM_ROB), .NUM_PR(64), .NUM_FL(32), .NUM_ARCH(32)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave),
    .rob_head(dbg_head), .rob_tail(dbg_tail), .rob_count(dbg_count));
`else
  rob #(.NUM_ROB(NUM_ROB), .NUM_PR(64), .NUM_FL(32), .NUM_ARCH(32)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave));
`endif

  typedef struct packed {
    logic [4:0] dest;
    logic [5:0] t;
    logic [5:0] t_old;
  } ret_t;

  ret_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   n_ret  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic clear_inputs();
    bus.dispatch_en      = 1'b0;
    bus.dispatch_dest    = '0;
    bus.dispatch_T       = '0;
    bus.dispatch_T_old   = '0;
    bus.dispatch_FL_idx  = '0;
    bus.complete_en      = 1'b0;
    bus.complete_rob_idx = '0;
    bus.rollback_en      = 1'b0;
    bus.rollback_rob_idx = '0;
  endtask

  // Start a new cycle: inputs change on the falling edge, away from posedge.
  task automatic cyc();
    @(negedge clock);
    clear_inputs();
  endtask

  task automatic disp(input int dest, input int t, input int t_old, input int fl);
    bus.dispatch_en     = 1'b1;
    bus.dispatch_dest   = 5'(dest);
    bus.dispatch_T      = 6'(t);
    bus.dispatch_T_old  = 6'(t_old);
    bus.dispatch_FL_idx = 5'(fl);
  endtask

  task automatic expect_ret(input int dest, input int t, input int t_old);
    ret_t e;
    e.dest  = 5'(dest);
    e.t     = 6'(t);
    e.t_old = 6'(t_old);
    exp_q.push_back(e);
  endtask

  task automatic cpl(input int idx);
    bus.complete_en      = 1'b1;
    bus.complete_rob_idx = 3'(idx);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    clear_inputs();
    #1 reset = 1'b0;
    #2 reset = 1'b1;
  endtask

  // Monitor: samples late in the low phase, after inputs have settled.
  initial begin
    ret_t e;
    forever begin
      @(negedge clock);
      #3;
      if (reset && bus.retire_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL retire_unexpected: got retire T=%0d, expected no retire", bus.retire_T);
        end else begin
          e = exp_q.pop_front();
          n_ret++;
          chk("retire_dest",  int'(bus.retire_dest), int'(e.dest));
          chk("retire_T",     int'(bus.retire_T),    int'(e.t));
          chk("retire_T_old", int'(bus.T_old_idx),   int'(e.t_old));
        end
      end
    end
  end

  initial begin
    clear_inputs();
    #2;
    chk("rst_rob_valid", int'(bus.rob_valid), 1);
    chk("rst_rob_idx",   int'(bus.rob_idx),   0);
    chk("rst_retire_en", int'(bus.retire_en), 0);
    chk("rst_T_old",     int'(bus.T_old_idx), 0);
    chk("rst_fl_rb",     int'(bus.FL_rollback_idx), 0);
    @(negedge clock);
    #1 reset = 1'b1;

    // Dispatch -> complete -> retire latency.
    cyc(); disp(3, 33, 5, 0); expect_ret(3, 33, 5);
    cyc(); cpl(0); #1 chk("early_retire", int'(bus.retire_en), 0);
    cyc(); #1 chk("lat_retire_en", int'(bus.retire_en), 1);
    cyc(); #1 chk("after_retire_en", int'(bus.retire_en), 0);
    chk("after_retire_idx", int'(bus.rob_idx), 1);

    // Asynchronous reset mid-run with a retire pending.
    disp(1, 10, 11, 1);
    cyc(); disp(2, 12, 13, 2);
    cyc(); cpl(1);
    cyc(); #1 chk("pre_rst_retire", int'(bus.retire_en), 1);
    chk("pre_rst_idx", int'(bus.rob_idx), 3);
    #1 reset = 1'b0;
    #1 chk("midrst_rob_valid", int'(bus.rob_valid), 1);
    chk("midrst_rob_idx",   int'(bus.rob_idx),   0);
    chk("midrst_retire_en", int'(bus.retire_en), 0);
    @(negedge clock);
    #2 reset = 1'b1;

    // Fill to capacity; a ninth dispatch is ignored.
    for (int i = 0; i < NUM_ROB; i++) begin
      cyc(); disp(i, 40 + i, 8 + i, i);
      if (i == NUM_ROB - 1) #1 chk("valid_before_full", int'(bus.rob_valid), 1);
    end
    cyc(); disp(20, 60, 61, 3);
    #1 chk("full_rob_valid", int'(bus.rob_valid), 0);
    chk("full_rob_idx", int'(bus.rob_idx), 0);
    cyc(); cpl(0); expect_ret(0, 40, 8);
    #1 chk("full_tail_stays", int'(bus.rob_idx), 0);
    // Retire at full: no same-cycle dispatch bypass.
    cyc(); disp(20, 60, 61, 3);
    #1 chk("full_retire_en", int'(bus.retire_en), 1);
    chk("full_retire_novalid", int'(bus.rob_valid), 0);
    cyc(); #1 chk("freed_rob_valid", int'(bus.rob_valid), 1);
    chk("freed_rob_idx", int'(bus.rob_idx), 0);
    disp(9, 50, 20, 7);
    cyc(); #1 chk("refull_rob_idx", int'(bus.rob_idx), 1);
    chk("refull_rob_valid", int'(bus.rob_valid), 0);

    // Rollback at entry 1 with entries 0..4 allocated, entry 0 completing.
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(); disp(i, 20 + i, 30 + i, 10 + i);
      if (i == 4) begin cpl(0); expect_ret(0, 20, 30); end
    end
    cyc();
    bus.rollback_en = 1'b1; bus.rollback_rob_idx = 3'd1;
    disp(25, 55, 56, 15); cpl(3);
    #1 chk("rb_fl_idx", int'(bus.FL_rollback_idx), 12);
    chk("rb_retire_suppressed", int'(bus.retire_en), 0);
    cyc(); #1 chk("rb_tail", int'(bus.rob_idx), 2);
    disp(1, 1, 1, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(); disp(2, 2, 2, 2);
    end
    cyc(); #1 chk("rb_count_not_full", int'(bus.rob_valid), 1);
    chk("rb_tail_wrap", int'(bus.rob_idx), 0);
    disp(3, 3, 3, 3);
    cyc(); #1 chk("rb_count_full", int'(bus.rob_valid), 0);
    chk("rb_tail_final", int'(bus.rob_idx), 1);

    // Advance head to 6, then wrap and complete out of order.
    pulse_reset();
    for (int k = 0; k < 6; k++) begin
      cyc(); disp(k, 40 + k, k, k); expect_ret(k, 40 + k, k);
      cyc(); cpl(k);
      cyc();
    end
    cyc(); #1 chk("wrap_head_idx", int'(bus.rob_idx), 6);
    for (int j = 0; j < 4; j++) begin
      if (j > 0) cyc();
      disp(10 + j, 50 + j, 2 + j, j); expect_ret(10 + j, 50 + j, 2 + j);
    end
    cyc(); #1 chk("wrap_tail", int'(bus.rob_idx), 2);
    cpl(1);
    cyc(); #1 chk("ooo_no_retire", int'(bus.retire_en), 0);
    cpl(6);
    cyc(); cpl(7);
    cyc(); cpl(0);
    repeat (4) cyc();
    #1 chk("sb_drained", exp_q.size(), 0);
    chk("retire_total", n_ret, 13);
    chk("end_rob_valid", int'(bus.rob_valid), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
